if_fetch_stage: RTL and testbench
=================================

// Module: if_fetch_stage
// PURPOSE
//  Instruction-fetch stage and IF/ID pipeline register; sits directly upstream of the controller.
//  Holds the PC and issues word fetches over a req/ack instruction-memory port.
//  Presents {valid, pc, instr} to decode, plus id_opcode = instr[6:2], which drives controller.opcode.
//  Supports decode back-pressure (stall) and branch/jump redirect (flush).
// PARAMETERS
//  XLEN      32            data/address width
//  RESET_PC  32'h0000_0000 PC loaded on reset; bits [1:0] must be 0
// PORTS
//  clk          in   1     single clock, rising edge
//  rst          in   1     synchronous, active-high reset
//  imem_req     out  1     fetch request; level, held until imem_ack
//  imem_addr    out  XLEN  fetch address = pc; stable while imem_req=1
//  imem_ack     in   1     request accepted; imem_rdata valid in the same cycle
//  imem_rdata   in   32    fetched instruction word
//  stall        in   1     decode cannot accept; hold IF/ID contents
//  redirect     in   1     taken branch/JAL/JALR; flush and refetch
//  redirect_pc  in   XLEN  new PC; bits [1:0] are ignored (forced to 0)
//  id_valid     out  1     IF/ID holds a real instruction
//  id_pc        out  XLEN  PC of id_instr
//  id_instr     out  32    instruction word; NOP (32'h0000_0013) when invalid
//  id_opcode    out  5     id_instr[6:2]; goes to controller
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   pc=RESET_PC, id_valid=0, id_pc=0, id_instr=NOP, skid empty, state=S_REQ.
//   imem_req=0 while rst=1.
//  Only one request is outstanding at a time. A fetch completes on the cycle with imem_req & imem_ack.
//  Decode accepts a new word when accept = !stall | !id_valid (a bubble never blocks).
//  State S_REQ (imem_req=1, imem_addr=pc):
//   - ack & accept: IF/ID <= {1, pc, rdata}; pc <= pc+4; stay in S_REQ.
//     This gives 1 instruction/cycle with a zero-wait memory.
//   - ack & !accept: skid <= {pc, rdata}; pc <= pc+4; go to S_WAIT.
//   - no ack: hold pc/addr; the IF/ID contents are unchanged.
//     If accept & id_valid, clear id_valid (decode consumed the word, nothing new arrived).
//  State S_WAIT (imem_req=0):
//   - while stall: hold everything.
//   - !stall: IF/ID <= skid; skid cleared; go to S_REQ.
//  Redirect has the highest priority and applies in any state, including while stalled:
//   - pc <= {redirect_pc[XLEN-1:2],2'b00}; id_valid <= 0; id_instr <= NOP; skid cleared; state=S_REQ.
//   - A word acked in the same cycle is discarded.
//  rst has priority over redirect. Reset in mid-S_WAIT discards the skid entry.
//  pc+4 wraps modulo 2^XLEN; there is no overflow flag.
//  id_valid=0 together with id_instr=NOP guarantees the controller decodes a harmless IMM_OP.
//  Latency: ack at cycle N -> id_valid/id_instr visible after posedge N+1.
// STRUCTURE
//  Shared package rv_pkg:
//   - opcode constants (R/IMM/LOAD/STORE/BRANCH/JAL/JALR/LUI/AUIPC/ENVIR)
//   - NOP_INSTR
//   - XLEN default
//   - FSM state encoding {S_REQ, S_WAIT}
//  One sub-module: if_id_reg, the IF/ID register with load/hold/flush controls and NOP reset value.
//  The PC, FSM and skid buffer stay in if_fetch_stage.
// TESTING
//  1 Reset, zero-wait memory (ack=1 always), rdata = addr-based pattern:
//    -> addresses 0,4,8,...; id_pc follows 1 cycle later; id_valid=1 from the 2nd cycle.
//  2 ack delayed 3 cycles per request:
//    -> imem_addr is stable across the wait; id_valid goes 1 for one cycle per word;
//       no word is skipped or duplicated.
//  3 stall=1 while id_valid=1 and ack returns pc=0x8:
//    -> IF/ID is held at 0x4; the word is skidded; imem_req=0.
//    -> On stall release: IF/ID=0x8, next addr=0xC.
//  4 redirect=1 to 0x103 in the same cycle as an ack for 0x20:
//    -> the 0x20 word is dropped; id_valid=0; next imem_addr=0x100.
//  5 redirect during S_WAIT with stall=1:
//    -> the skid is discarded; id_instr=NOP; fetch resumes at redirect_pc.
//  6 rst during S_WAIT and during a pending request; pc near 0xFFFF_FFFC:
//    -> reset values as specified, then fetch from RESET_PC.
//    -> A separate wrap case: 0xFFFF_FFFC+4 -> 0x0.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV definitions: opcode field values (instr[6:2]), NOP word, default
// width and the fetch FSM state encoding.
package rv_pkg;
  localparam int XLEN = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  localparam logic [4:0] R_OP      = 5'b01100;
  localparam logic [4:0] IMM_OP    = 5'b00100;
  localparam logic [4:0] LOAD_OP   = 5'b00000;
  localparam logic [4:0] STORE_OP  = 5'b01000;
  localparam logic [4:0] BRANCH_OP = 5'b11000;
  localparam logic [4:0] JAL_OP    = 5'b11011;
  localparam logic [4:0] JALR_OP   = 5'b11001;
  localparam logic [4:0] LUI_OP    = 5'b01101;
  localparam logic [4:0] AUIPC_OP  = 5'b00101;
  localparam logic [4:0] ENVIR_OP  = 5'b11100;

  typedef enum logic {S_REQ = 1'b0, S_WAIT = 1'b1} fetch_state_t;
endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory req/ack port. The fetch stage is the master.
interface if_fetch_stage_if #(parameter int XLEN = rv_pkg::XLEN);
  logic            req;
  logic [XLEN-1:0] addr;
  logic            ack;
  logic [31:0]     rdata;

  modport master (output req, addr, input ack, rdata);
  modport slave  (input req, addr, output ack, rdata);
endinterface

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register. Flush wins over load; a flushed or reset entry
// carries NOP so decode always sees a harmless IMM_OP.
module if_id_reg
  import rv_pkg::*;
#(
  parameter int XLEN = rv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            flush,
  input  logic [XLEN-1:0] d_pc,
  input  logic [31:0]     d_instr,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     instr
);

  // Register update: reset > flush > load > hold
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= NOP_INSTR;
    end else if (flush) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= d_pc;
      instr <= d_instr;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC, one-outstanding-request fetch FSM, one-entry
// skid buffer for a word that arrives while decode is stalled, IF/ID register.
module if_fetch_stage
  import rv_pkg::*;
#(
  parameter int              XLEN     = rv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  if_fetch_stage_if.master imem,
  input  logic             stall,
  input  logic             redirect,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             id_valid,
  output logic [XLEN-1:0]  id_pc,
  output logic [31:0]      id_instr,
  output logic [4:0]       id_opcode
);

  fetch_state_t    state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic            skid_vld, skid_vld_n;
  logic [XLEN-1:0] skid_pc, skid_pc_n;
  logic [31:0]     skid_instr, skid_instr_n;
  logic            ld, fl;
  logic [XLEN-1:0] ld_pc;
  logic [31:0]     ld_instr;
  logic            accept;
  logic            unused_rpc_lsb;

  assign imem.req  = (state == S_REQ) && !rst;
  assign imem.addr = pc;
  assign accept    = !stall || !id_valid;
  assign id_opcode = id_instr[6:2];
  assign unused_rpc_lsb = ^redirect_pc[1:0];

  // Fetch state, PC and skid entry
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      skid_vld   <= 1'b0;
      skid_pc    <= '0;
      skid_instr <= NOP_INSTR;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      skid_vld   <= skid_vld_n;
      skid_pc    <= skid_pc_n;
      skid_instr <= skid_instr_n;
    end
  end

  // Next state, IF/ID load/flush control; redirect overrides everything
  always_comb begin
    state_n      = state;
    pc_n         = pc;
    skid_vld_n   = skid_vld;
    skid_pc_n    = skid_pc;
    skid_instr_n = skid_instr;
    ld           = 1'b0;
    fl           = 1'b0;
    ld_pc        = pc;
    ld_instr     = imem.rdata;
    if (redirect) begin
      pc_n       = {redirect_pc[XLEN-1:2], 2'b00};
      fl         = 1'b1;
      skid_vld_n = 1'b0;
      state_n    = S_REQ;
    end else begin
      case (state)
        S_REQ: begin
          if (imem.ack) begin
            pc_n = pc + XLEN'(4);
            if (accept) begin
              ld = 1'b1;
            end else begin
              skid_vld_n   = 1'b1;
              skid_pc_n    = pc;
              skid_instr_n = imem.rdata;
              state_n      = S_WAIT;
            end
          end else if (accept && id_valid) begin
            // decode took the word and nothing new arrived: leave a bubble
            fl = 1'b1;
          end
        end
        S_WAIT: begin
          if (!stall) begin
            ld         = 1'b1;
            ld_pc      = skid_pc;
            ld_instr   = skid_instr;
            skid_vld_n = 1'b0;
            state_n    = S_REQ;
          end
        end
        default: state_n = S_REQ;
      endcase
    end
  end

  if_id_reg #(.XLEN(XLEN)) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .load    (ld),
    .flush   (fl),
    .d_pc    (ld_pc),
    .d_instr (ld_instr),
    .valid   (id_valid),
    .pc      (id_pc),
    .instr   (id_instr)
  );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: per-cycle vector table plus hand-written
// sequences for zero-wait streaming, delayed ack, reset in flight and PC wrap.
module tb_if_fetch_stage;
  import rv_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [4:0]  id_opcode;
  logic        ack_drv = 1'b0;
  logic        dly_mode = 1'b0;
  logic [3:0]  wcnt = '0;

  int total = 0;
  int bad = 0;

  if_fetch_stage_if #(.XLEN(32)) imem ();

  if_fetch_stage #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem        (imem.master),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_valid    (id_valid),
    .id_pc       (id_pc),
    .id_instr    (id_instr),
    .id_opcode   (id_opcode)
  );

  always #5 clk = ~clk;

  // memory model: word = address + 0x1000_0000
  assign imem.rdata = imem.addr + 32'h1000_0000;
  assign imem.ack   = dly_mode ? (imem.req && wcnt == 4'd3) : ack_drv;

  always @(posedge clk) begin
    if (!imem.req || imem.ack) wcnt <= '0;
    else                       wcnt <= wcnt + 4'd1;
  end

  function automatic logic [31:0] pat(input logic [31:0] a);
    return a + 32'h1000_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; ack_drv = 1'b0;
    @(negedge clk); chk("rst_req", {31'b0, imem.req}, 32'd0);
    cyc();
    @(negedge clk); chk("rst_req2", {31'b0, imem.req}, 32'd0);
    cyc();
    rst = 1'b0;
  endtask

  typedef struct {
    logic        stall, redir, ack;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc, instr;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int words;
    logic [31:0] exp_pc, prev_addr;
    logic prev_vld, prev_req, prev_ack;

    //          stall redir ack  rpc           req  addr          vld  pc            instr
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 32'h0,       1'b1, 32'h0,       1'b0, 32'h0,       NOP};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 32'h0,       1'b1, 32'h4,       1'b1, 32'h0,       pat(32'h0)};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 32'h0,       1'b1, 32'h8,       1'b1, 32'h4,       pat(32'h4)};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,       1'b0, 32'hC,       1'b1, 32'h4,       pat(32'h4)};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'hC,       1'b1, 32'h4,       pat(32'h4)};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 32'hC,       1'b1, 32'h8,       pat(32'h8)};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 32'hC,       1'b0, 32'h8,       NOP};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 32'h0,       1'b1, 32'hC,       1'b0, 32'h8,       NOP};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 32'h103,     1'b1, 32'h10,      1'b1, 32'hC,       pat(32'hC)};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 32'h100,     1'b0, 32'hC,       NOP};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 32'h0,       1'b1, 32'h100,     1'b0, 32'hC,       NOP};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 32'h0,       1'b1, 32'h104,     1'b1, 32'h100,     pat(32'h100)};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 32'h202,     1'b0, 32'h108,     1'b1, 32'h100,     pat(32'h100)};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 32'h0,       1'b1, 32'h200,     1'b0, 32'h100,     NOP};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 32'h0,       1'b1, 32'h200,     1'b0, 32'h100,     NOP};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 32'h204,     1'b1, 32'h200,     pat(32'h200)};

    // reset state
    cyc();
    @(negedge clk);
    chk("rst_valid", {31'b0, id_valid}, 32'd0);
    chk("rst_instr", id_instr, NOP);
    do_reset();
    @(negedge clk);
    chk("rst_addr", imem.addr, 32'h0);
    chk("rst_idpc", id_pc, 32'h0);
    chk("rst_opc", {27'b0, id_opcode}, {27'b0, IMM_OP});

    // zero-wait streaming
    do_reset();
    ack_drv = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("zw_addr", imem.addr, 32'(4 * i));
      chk("zw_valid", {31'b0, id_valid}, (i == 0) ? 32'd0 : 32'd1);
      if (i > 0) begin
        chk("zw_pc", id_pc, 32'(4 * (i - 1)));
        chk("zw_instr", id_instr, pat(32'(4 * (i - 1))));
      end
      cyc();
    end

    // vector table: stall/skid, consume bubble, redirects
    do_reset();
    for (int i = 0; i < 16; i++) begin
      stall = tbl[i].stall; redirect = tbl[i].redir;
      redirect_pc = tbl[i].rpc; ack_drv = tbl[i].ack;
      @(negedge clk);
      chk($sformatf("v%0d_req", i), {31'b0, imem.req}, {31'b0, tbl[i].req});
      chk($sformatf("v%0d_addr", i), imem.addr, tbl[i].addr);
      chk($sformatf("v%0d_valid", i), {31'b0, id_valid}, {31'b0, tbl[i].vld});
      chk($sformatf("v%0d_pc", i), id_pc, tbl[i].pc);
      chk($sformatf("v%0d_instr", i), id_instr, tbl[i].instr);
      cyc();
    end
    stall = 1'b0; redirect = 1'b0; ack_drv = 1'b0;

    // ack delayed 3 cycles per request
    dly_mode = 1'b1;
    do_reset();
    words = 0; exp_pc = 32'h0; prev_vld = 1'b0; prev_req = 1'b0;
    prev_ack = 1'b0; prev_addr = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (prev_req && !prev_ack && imem.req)
        chk("dly_addr_stable", imem.addr, prev_addr);
      if (id_valid) begin
        chk("dly_pc", id_pc, exp_pc);
        chk("dly_instr", id_instr, pat(exp_pc));
        chk("dly_pulse", {31'b0, prev_vld}, 32'd0);
        exp_pc += 32'd4;
        words++;
      end
      prev_vld = id_valid; prev_req = imem.req;
      prev_ack = imem.ack; prev_addr = imem.addr;
      cyc();
    end
    chk("dly_words", 32'(words), 32'd9);
    dly_mode = 1'b0;

    // reset during S_WAIT discards the skid entry
    do_reset();
    ack_drv = 1'b1; cyc();
    stall = 1'b1; cyc();
    ack_drv = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("rw_req", {31'b0, imem.req}, 32'd0);
    cyc();
    rst = 1'b0; stall = 1'b0;
    @(negedge clk);
    chk("rw_valid", {31'b0, id_valid}, 32'd0);
    chk("rw_instr", id_instr, NOP);
    chk("rw_addr", imem.addr, 32'h0);
    chk("rw_req1", {31'b0, imem.req}, 32'd1);
    ack_drv = 1'b1; cyc();
    ack_drv = 1'b0;
    @(negedge clk);
    chk("rw_pc", id_pc, 32'h0);
    chk("rw_word", id_instr, pat(32'h0));

    // reset during a pending request near the top of the address space
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8; cyc();
    redirect = 1'b0;
    @(negedge clk);
    chk("rp_addr", imem.addr, 32'hFFFF_FFF8);
    rst = 1'b1;
    @(negedge clk);
    chk("rp_req", {31'b0, imem.req}, 32'd0);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("rp_addr0", imem.addr, 32'h0);
    chk("rp_idpc", id_pc, 32'h0);
    chk("rp_valid", {31'b0, id_valid}, 32'd0);

    // PC wrap
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; cyc();
    redirect = 1'b0; ack_drv = 1'b1;
    @(negedge clk);
    chk("wr_addr", imem.addr, 32'hFFFF_FFFC);
    cyc();
    ack_drv = 1'b0;
    @(negedge clk);
    chk("wr_addr0", imem.addr, 32'h0);
    chk("wr_pc", id_pc, 32'hFFFF_FFFC);
    chk("wr_instr", id_instr, pat(32'hFFFF_FFFC));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
